// File: rtl/adder_tree_operand_sequencer.sv
// Operand sequencer for a 5-input pipelined adder tree: collects operands, waits out the tree
// latency, returns the sum. Define ADDER_TREE_SEQ_CHECK_EN to add a running-sum cross-check.
module adder_tree_operand_sequencer #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned NUM_OPS      = 5,
    parameter int unsigned TREE_LATENCY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] tree_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef ADDER_TREE_SEQ_CHECK_EN
    output logic             check_err,
`endif
    output logic             busy
);

    localparam logic [2:0] LastOp  = 3'(NUM_OPS - 1);
    localparam logic [3:0] LastLat = 4'(TREE_LATENCY - 1);

    typedef enum logic [1:0] {StCollect, StWait, StResult} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_cnt_q, op_cnt_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q, e_q;
    logic [WIDTH-1:0] a_d, b_d, c_d, d_d, e_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             in_fire;
    logic             capture;

    assign in_fire = (state_q == StCollect) && in_valid;
    assign capture = (state_q == StWait) && (lat_cnt_q == LastLat);

    always_comb begin
        state_d    = state_q;
        op_cnt_d   = op_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        e_d        = e_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StCollect: begin
                if (in_fire) begin
                    case (op_cnt_q)
                        3'd0:    a_d = in_data;
                        3'd1:    b_d = in_data;
                        3'd2:    c_d = in_data;
                        3'd3:    d_d = in_data;
                        default: e_d = in_data;
                    endcase
                    if (op_cnt_q == LastOp) begin
                        op_cnt_d  = 3'd0;
                        lat_cnt_d = 4'd0;
                        state_d   = StWait;
                    end else begin
                        op_cnt_d = op_cnt_q + 3'd1;
                    end
                end
            end
            StWait: begin
                lat_cnt_d = lat_cnt_q + 4'd1;
                if (capture) begin
                    out_data_d = tree_out;
                    state_d    = StResult;
                end
            end
            StResult: begin
                if (out_ready) state_d = StCollect;
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StCollect;
            op_cnt_q   <= 3'd0;
            lat_cnt_q  <= 4'd0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            e_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_cnt_q   <= op_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            e_q        <= e_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef ADDER_TREE_SEQ_CHECK_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             err_q, err_d;

    // First operand restarts the sum so no clear is needed between transactions.
    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (in_fire) sum_d = (op_cnt_q == 3'd0) ? in_data : sum_q + in_data;
        if (capture && (tree_out != sum_q)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign check_err = err_q;
`endif

    assign in_ready  = (state_q == StCollect);
    assign out_valid = (state_q == StResult);
    assign busy      = !((state_q == StCollect) && (op_cnt_q == 3'd0));
    assign out_data  = out_data_q;
    assign A         = a_q;
    assign B         = b_q;
    assign C         = c_q;
    assign D         = d_q;
    assign E         = e_q;

endmodule

// File: tb/tb_adder_tree_operand_sequencer.sv
// Directed bench for adder_tree_operand_sequencer with a behavioural 3-cycle adder tree model.
module tb_adder_tree_operand_sequencer;

    localparam int unsigned TL = 3;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] A, B, C, D, E;
    logic [15:0] tree_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
`ifdef ADDER_TREE_SEQ_CHECK_EN
    logic        check_err;
`endif

    logic        force_en;
    logic [15:0] force_val;
    logic [15:0] p0, p1;

    int n_cmp;
    int n_err;

    adder_tree_operand_sequencer #(
        .WIDTH        (16),
        .NUM_OPS      (5),
        .TREE_LATENCY (TL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .E         (E),
        .tree_out  (tree_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ADDER_TREE_SEQ_CHECK_EN
        .check_err (check_err),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tree model: result of A..E stable after edge 0 is visible on tree_out before edge TL.
    always_ff @(posedge clk) begin
        p0 <= A + B + C + D + E;
        p1 <= p0;
    end
    assign tree_out = force_en ? force_val : p1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
    endtask

    task automatic gap();
        in_valid = 1'b0;
        in_data  = 16'hAAAA;
        tick();
    endtask

    // Called right after the edge that wrote E.
    task automatic expect_result(input string tag, input logic [15:0] exp);
        in_valid = 1'b0;
        chk({tag, "_wait_in_ready"}, {15'd0, in_ready}, 16'd0);
        chk({tag, "_wait_busy"}, {15'd0, busy}, 16'd1);
        for (int i = 1; i < TL; i++) begin
            tick();
            chk({tag, "_early_valid"}, {15'd0, out_valid}, 16'd0);
        end
        tick();
        chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_data"}, out_data, exp);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, {15'd0, out_valid}, 16'd0);
        chk({tag, "_post_in_ready"}, {15'd0, in_ready}, 16'd1);
        chk({tag, "_post_busy"}, {15'd0, busy}, 16'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        force_en  = 1'b0;
        force_val = 16'h0;
        tick();
        tick();
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_A", A, 16'h0);
        chk("rst_E", E, 16'h0);
        reset = 1'b0;
        tick();

        // 1..5 with in_valid held high
        feed(16'd1);
        chk("t1_busy_mid", {15'd0, busy}, 16'd1);
        feed(16'd2);
        feed(16'd3);
        feed(16'd4);
        feed(16'd5);
        chk("t1_A", A, 16'd1);
        chk("t1_B", B, 16'd2);
        chk("t1_C", C, 16'd3);
        chk("t1_D", D, 16'd4);
        chk("t1_E", E, 16'd5);
        expect_result("t1", 16'h000F);
        handshake("t1");

        // wrap-around
        for (int i = 0; i < 5; i++) feed(16'hFFFF);
        expect_result("t2", 16'hFFFB);
`ifdef ADDER_TREE_SEQ_CHECK_EN
        chk("t2_check_err", {15'd0, check_err}, 16'd0);
`endif
        handshake("t2");

        // back-pressure on the result; operand during RESULT and at handshake ignored
        feed(16'h0010);
        feed(16'h0020);
        feed(16'h0030);
        feed(16'h0040);
        feed(16'h0050);
        expect_result("t3", 16'h00F0);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            in_data  = 16'h0077;
            tick();
            chk("t3_hold_valid", {15'd0, out_valid}, 16'd1);
            chk("t3_hold_data", out_data, 16'h00F0);
            chk("t3_hold_in_ready", {15'd0, in_ready}, 16'd0);
        end
        chk("t3_A_untouched", A, 16'h0010);
        in_valid = 1'b1;
        in_data  = 16'h0099;
        handshake("t3");
        in_valid = 1'b0;
        chk("t3_hs_op_rejected", A, 16'h0010);

        // gapped operands
        feed(16'd7);
        gap();
        feed(16'd0);
        gap();
        feed(16'd0);
        gap();
        feed(16'd0);
        gap();
        chk("t4_still_collect", {15'd0, in_ready}, 16'd1);
        chk("t4_A", A, 16'd7);
        chk("t4_D", D, 16'd0);
        feed(16'd9);
        chk("t4_E", E, 16'd9);
        expect_result("t4", 16'h0010);
        handshake("t4");

        // reset mid-transaction
        feed(16'd8);
        feed(16'd8);
        feed(16'd8);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        chk("t5_A", A, 16'd0);
        chk("t5_C", C, 16'd0);
        chk("t5_out_data", out_data, 16'd0);
        chk("t5_in_ready", {15'd0, in_ready}, 16'd1);
        chk("t5_busy", {15'd0, busy}, 16'd0);
        for (int i = 0; i < 5; i++) feed(16'd2);
        chk("t5_A2", A, 16'd2);
        chk("t5_E2", E, 16'd2);
        expect_result("t5", 16'h000A);
        handshake("t5");

        // wrong tree result
        force_en  = 1'b1;
        force_val = 16'h1234;
        feed(16'd1);
        feed(16'd2);
        feed(16'd3);
        feed(16'd4);
        feed(16'd5);
        expect_result("t6", 16'h1234);
`ifdef ADDER_TREE_SEQ_CHECK_EN
        chk("t6_check_err", {15'd0, check_err}, 16'd1);
`endif
        force_en = 1'b0;
        handshake("t6");
        tick();
        tick();
`ifdef ADDER_TREE_SEQ_CHECK_EN
        chk("t6_sticky", {15'd0, check_err}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_cleared", {15'd0, check_err}, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_tree_operand_sequencer.md
Name: adder_tree_operand_sequencer

Overview:
- Initiator-side companion to the 5-input, 16-bit pipelined binary adder tree.
- Accepts operands one at a time on a valid/ready stream and drives them in parallel onto the tree's A..E inputs.
- Waits the tree's fixed pipeline latency, captures the tree output, and returns it on a valid/ready result stream.
- Converts the tree's parallel, free-running interface into a flow-controlled transaction interface.

Parameters:
- WIDTH, 16, operand and result width; must match the tree.
- NUM_OPS, 5, operands per transaction; fixed at 5 to match the tree's A..E inputs.
- TREE_LATENCY, 3, clk cycles from the tree's A..E inputs being stable to tree_out being valid; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand strobe
- in_ready  output  1  sequencer can accept an operand
- in_data  input  WIDTH  operand value
- A  output  WIDTH  tree operand 0
- B  output  WIDTH  tree operand 1
- C  output  WIDTH  tree operand 2
- D  output  WIDTH  tree operand 3
- E  output  WIDTH  tree operand 4
- tree_out  input  WIDTH  tree result (tree's out port)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  captured sum
- busy  output  1  high in any state other than COLLECT with op_cnt==0

Behaviour:
- Reset, sampled on posedge clk:
  - state=COLLECT, op_cnt=0, lat_cnt=0.
  - A..E=0, out_data=0, out_valid=0, in_ready=1, busy=0.
  - Reset overrides every other event. An in-flight transaction is discarded and no result is produced for it.
- State COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready, in_data is written to operand slot op_cnt (0→A, 1→B, 2→C, 3→D, 4→E) and op_cnt increments.
  - Once the 5th operand is accepted: op_cnt→0, lat_cnt→0, state→WAIT on the next cycle.
  - in_valid low means no change. Gaps between operands are allowed.
- State WAIT:
  - in_ready=0. A..E are held stable.
  - lat_cnt increments every cycle.
  - When lat_cnt==TREE_LATENCY-1: out_data<=tree_out, out_valid<=1, state→RESULT. The capture edge is exactly TREE_LATENCY cycles after the edge at which E was written.
- State RESULT:
  - out_valid=1, in_ready=0. out_data and A..E are held.
  - On out_valid&&out_ready: out_valid→0, state→COLLECT, and in_ready is 1 from the following cycle.
  - An operand presented in the same cycle as the out handshake is not accepted.
- Arithmetic: the sum is modulo 2^WIDTH. The tree wraps and the sequencer adds nothing. No overflow flag.
- A..E keep their last values after the transaction and are overwritten slot by slot during the next COLLECT.
- Throughput: at most one transaction per 5+TREE_LATENCY+1 cycles, with no back-to-back overlap.
- out_ready high while out_valid is low has no effect.
- in_valid high while in_ready is low is ignored, and in_data is not consumed.

Optional Feature:
- Macro: ADDER_TREE_SEQ_CHECK_EN.
- When defined:
  - Adds output port check_err (1 bit, reset 0).
  - A local WIDTH-bit running sum of the accepted operands, modulo 2^WIDTH, is built during COLLECT.
  - At the capture edge, if tree_out != running sum, check_err sets and is sticky until reset.
  - out_data still carries tree_out.
- When undefined: no check_err port and no running-sum logic. All other behaviour is identical.

Test Plan:
- Operands 1,2,3,4,5 with in_valid held high for 5 cycles → A..E=1..5. out_valid rises 3 cycles after E is written, with out_data=0x000F. With out_ready=1, returns to COLLECT and in_ready=1 the next cycle.
- Five operands of 0xFFFF → out_data=0xFFFB (wrap). check_err stays 0 when the macro is enabled.
- Operands 0x0010,0x0020,0x0030,0x0040,0x0050 with out_ready=0 for 10 cycles after out_valid → out_valid and out_data=0x00F0 are held stable, in_ready=0, and an in_valid pulse meanwhile is ignored. After out_ready=1, the next transaction starts cleanly.
- in_valid toggled 1,0,1,0,... across operands 7,0,0,0,9 → exactly 5 acceptances, out_data=0x0010.
- reset asserted for 1 cycle after 3 operands are accepted → all outputs are 0 and in_ready=1. Five fresh operands 2,2,2,2,2 then produce out_data=0x000A.
- With ADDER_TREE_SEQ_CHECK_EN, tree_out forced to 0x1234 during operands 1..5 → check_err=1 at the capture edge and stays high until reset. out_data=0x1234.
